// File: rtl/snn_pkg.sv
// Shared spike-routing types and widths for the delay buffer, serializer and neuron array.
package snn_pkg;

  localparam int SPIKE_W      = 48;
  localparam int SPIKE_ADDR_W = 6;

  typedef struct packed {
    logic [SPIKE_ADDR_W-1:0] addr;
    logic                    last;
  } spike_evt_t;

endpackage

// File: rtl/lsb_encoder.sv
// Lowest-set-bit encoder: index, one-hot clear mask, any-bit and single-bit flags.
// Purely combinational; shared by the spike-routing blocks.
module lsb_encoder #(
  parameter int WIDTH  = 48,
  parameter int ADDR_W = 6
) (
  input  logic [WIDTH-1:0]  i_vec,
  output logic [ADDR_W-1:0] o_idx,
  output logic [WIDTH-1:0]  o_clr,
  output logic              o_any,
  output logic              o_single
);

  // Scan from the top so the last hit is the lowest set bit.
  always_comb begin
    o_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_vec[i]) begin
        o_idx = ADDR_W'(i);
      end
    end
  end

  assign o_clr    = i_vec & (~i_vec + WIDTH'(1));
  assign o_any    = (i_vec != '0);
  assign o_single = o_any && ((i_vec & (i_vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/spike_event_serializer.sv
// Captures delayed spike words, queues them in a small FIFO and emits one address event per set bit.
// Words arriving while the mask and FIFO are both full are dropped and flagged on the sticky OVF.
module spike_event_serializer
  import snn_pkg::*;
#(
  parameter int WIDTH      = SPIKE_W,
  parameter int ADDR_W     = SPIKE_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [WIDTH-1:0]  D,
  output logic              EVT_VALID,
  output logic [ADDR_W-1:0] EVT_ADDR,
  output logic              EVT_LAST,
  input  logic              EVT_READY,
  output logic              OVF,
  input  logic              OVF_CLR,
  output logic              BUSY
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic                 r_vld_d;
  logic [WIDTH-1:0]     r_mask;
  logic [WIDTH-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_ovf;

  logic [ADDR_W-1:0]    w_idx;
  logic [WIDTH-1:0]     w_clr;
  logic                 w_any;
  logic                 w_single;
  logic                 w_fifo_empty;
  logic                 w_fire;
  logic                 w_mask_free;
  logic                 w_push_req;
  logic                 w_pop;
  logic                 w_bypass;
  logic                 w_push_fifo;
  logic                 w_push_ok;
  logic                 w_drop;
  spike_evt_t           w_evt;

  lsb_encoder #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W)
  ) u_enc (
    .i_vec    (r_mask),
    .o_idx    (w_idx),
    .o_clr    (w_clr),
    .o_any    (w_any),
    .o_single (w_single)
  );

  // The mask is free when it is already empty or its last bit is consumed this cycle;
  // a free mask takes the FIFO head first, and only takes D directly when the FIFO is empty.
  assign w_fifo_empty = (r_count == '0);
  assign w_fire       = w_any && EVT_READY;
  assign w_mask_free  = !w_any || (w_fire && w_single);
  assign w_push_req   = r_vld_d && (D != '0);
  assign w_pop        = w_mask_free && !w_fifo_empty;
  assign w_bypass     = w_push_req && w_mask_free && w_fifo_empty;
  assign w_push_fifo  = w_push_req && !w_bypass;
  assign w_push_ok    = w_push_fifo && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);
  assign w_drop       = w_push_fifo && !w_push_ok;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_vld_d <= 1'b0;
    end else begin
      r_vld_d <= IN_VALID;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_mask <= '0;
    end else if (w_pop) begin
      r_mask <= r_mem[r_rd_ptr];
    end else if (w_bypass) begin
      r_mask <= D;
    end else if (w_fire) begin
      r_mask <= r_mask & ~w_clr;
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= D;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (OVF_CLR) begin
      r_ovf <= 1'b0;
    end
  end

  assign w_evt     = '{addr: w_idx, last: w_single};
  assign EVT_VALID = w_any;
  assign EVT_ADDR  = w_evt.addr;
  assign EVT_LAST  = w_evt.last;
  assign OVF       = r_ovf;
  assign BUSY      = r_vld_d || !w_fifo_empty || w_any;

endmodule
